alu: RTL and testbench
======================

Name: alu

Overview:
- Registered W-bit arithmetic/logic unit for the accumulator datapath.
- Each clock it applies the operation selected by `alu_op` to signed operands `operandA` and `operandB`.
- It captures the result into the accumulator output register and updates a 4-bit status flag register.
- Outputs feed the register file and the branch/condition logic.

Parameters:
- W, 16, operand/result width in bits (W ≥ 4, power of two).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- alu_op  input  5  operation select
- operandA  input  W  signed operand A (accumulator side)
- operandB  input  W  signed operand B (source side)
- resultAccumulator  output  W  registered signed result
- flags  output  4  registered status: [3]=Z zero, [2]=N negative, [1]=C carry/borrow, [0]=V signed overflow

Behaviour:
- Reset: rst_n low immediately (asynchronously) clears resultAccumulator and flags to 0. Reset asserted mid-operation discards the pending result. The first capture happens on the first rising edge after rst_n deasserts.
- Latency: one cycle. Inputs are sampled at the rising edge, and outputs are valid after that edge. There is no handshake; the unit captures every cycle.
- Opcodes (anything not listed = NOP: result and flags hold):
  - 00000 ADD: A+B. C = unsigned carry out of bit W-1. V = signed overflow.
  - 00001 SUB: A−B. C = borrow (1 when A < B unsigned). V = signed overflow.
  - 00010 AND: A&B
  - 00011 OR: A|B
  - 00100 MOV: result = operandB. operandA is ignored.
  - 00101 XOR: A^B
  - 00110 NOT: ~A
  - 00111 LSL: A << B[log2W-1:0]
  - 01000 LSR: logical right shift of A by B[log2W-1:0]
  - 01001 ASR: arithmetic right shift of A by B[log2W-1:0]
  - 01010 INC: A+1, flags as ADD with B=1
  - 01011 DEC: A−1, flags as SUB with B=1
  - 01100 CMP: flags as SUB(A,B); resultAccumulator holds its previous value
  - 01101 TST: Z,N from A&B, C=V=0; resultAccumulator holds
  - 01110 MUL: low W bits of signed A×B. C=V=1 when the full 2W product is not the sign extension of its low W bits.
- Flag rules:
  - Z=1 iff the computed W-bit value is 0. N = bit W-1 of the computed value. For CMP/TST, the computed value is the internal one, not the held result.
  - Logic ops (AND, OR, XOR, NOT) and MOV: C=0, V=0.
  - Shifts: C = last bit shifted out (0 when amount = 0); V=0.
- Shift amount uses only the low log2(W) bits of operandB; upper bits are ignored. An amount of 0 passes A through unchanged.
- Arithmetic wraps modulo 2^W. There is no saturation.
- Internal next-state logic is purely combinational from the current inputs. There is no dependence on the previous result except hold behaviour (CMP, TST, NOP).

Test Plan:
- Reset then MOV: rst_n low → result=0, flags=0. Release, then MOV A=32, B=5 → after 1 edge: result=5, flags=0000. MOV A=−13, B=−3 → result=−3 (0xFFFD), flags=0100. MOV A=−9, B=1 → result=1, flags=0000.
- ADD overflow/carry:
  - 0x7FFF+0x0001 → 0x8000, flags=0101 (N, V).
  - 0xFFFF+0x0001 → 0x0000, flags=1010 (Z, C).
- SUB/CMP:
  - SUB 5−5 → 0, flags=1000.
  - SUB 3−5 → −2, flags=0110.
  - Load 7 via MOV, then CMP A=2, B=9 → result stays 7, flags=0110.
- Shifts and logic:
  - LSL 0x8001 by 1 → 0x0002, C=1.
  - ASR 0x8000 by 15 → 0xFFFF, N=1.
  - LSR 0x8000 by B=0x0013 (amount 3) → 0x1000.
  - AND 0x0F0F & 0xF0F0 → 0, Z=1.
- MUL/NOP:
  - MUL 300×300 → 0x5F90, C=V=1.
  - MUL −4×5 → −20, N=1, C=V=0.
  - Undefined opcode 11111 → result and flags unchanged.
- Async reset mid-stream: assert rst_n low between clock edges during an ADD sequence → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu.sv
// Registered W-bit arithmetic/logic unit for the accumulator datapath.
// Each cycle the operation chosen by alu_op is applied to operandA/operandB.
// The W-bit result lands in resultAccumulator and the Z/N/C/V status in flags.
// CMP, TST and undefined opcodes leave the result register untouched, and
// undefined opcodes also hold the flags.
module alu #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);

    // Width of the shift-amount field taken from operandB.
    localparam int SW = $clog2(W);

    // The constant 1, used as the implicit operand of INC and DEC.
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [4:0] {
        OP_ADD = 5'b00000,
        OP_SUB = 5'b00001,
        OP_AND = 5'b00010,
        OP_OR  = 5'b00011,
        OP_MOV = 5'b00100,
        OP_XOR = 5'b00101,
        OP_NOT = 5'b00110,
        OP_LSL = 5'b00111,
        OP_LSR = 5'b01000,
        OP_ASR = 5'b01001,
        OP_INC = 5'b01010,
        OP_DEC = 5'b01011,
        OP_CMP = 5'b01100,
        OP_TST = 5'b01101,
        OP_MUL = 5'b01110
    } alu_op_e;

    // ------------------------------------------------------------------
    // Flag helper functions
    // ------------------------------------------------------------------

    // Signed overflow of a + b: operands agree in sign, sum disagrees.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Signed overflow of a - b: operands differ in sign, difference
    // takes the sign of b.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    // The full product fits in W bits only if its top half is the sign
    // extension of the low half.
    function automatic logic mul_ovf(input logic [2*W-1:0] p);
        return p[2*W-1:W] != {W{p[W-1]}};
    endfunction

    // Assemble {Z, N, C, V} from a computed value and its carry/overflow.
    function automatic logic [3:0] pack_flags(input logic [W-1:0] value,
                                              input logic c,
                                              input logic v);
        return {(value == {W{1'b0}}), value[W-1], c, v};
    endfunction

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    alu_op_e             op_s;
    logic [W-1:0]        addend_s;
    logic [W:0]          sum_s;
    logic [W:0]          diff_s;
    logic [SW-1:0]       shamt_s;
    logic [W:0]          lsl_s;
    logic [W:0]          lsr_s;
    logic signed [W:0]   asr_s;
    logic [2*W-1:0]      prod_s;

    logic [W-1:0]        value_s;
    logic                carry_s;
    logic                ovf_s;
    logic                load_res_s;
    logic                load_flags_s;

    logic [W-1:0]        res_q;
    logic [W-1:0]        res_d;
    logic [3:0]          flags_q;
    logic [3:0]          flags_d;

    assign op_s    = alu_op_e'(alu_op);
    assign shamt_s = operandB[SW-1:0];

    // INC and DEC reuse the adder and subtractor with an implicit operand of 1.
    always_comb begin
        addend_s = operandB;
        if ((op_s == OP_INC) || (op_s == OP_DEC)) begin
            addend_s = ONE_W;
        end else begin
            addend_s = operandB;
        end
    end

    // Shared arithmetic, shift and multiply units. Each is widened by one
    // bit so that the carry, borrow or last shifted-out bit appears as an
    // extra bit. A shift amount of 0 leaves that extra bit clear.
    always_comb begin
        sum_s  = {1'b0, operandA} + {1'b0, addend_s};
        diff_s = {1'b0, operandA} - {1'b0, addend_s};
        lsl_s  = {1'b0, operandA} << shamt_s;
        lsr_s  = {operandA, 1'b0} >> shamt_s;
        asr_s  = $signed({operandA, 1'b0}) >>> shamt_s;
        prod_s = {{W{operandA[W-1]}}, operandA} * {{W{operandB[W-1]}}, operandB};
    end

    // Operation decode: select the computed value and its carry/overflow,
    // and decide whether the result and/or flag registers load this cycle.
    always_comb begin
        value_s      = {W{1'b0}};
        carry_s      = 1'b0;
        ovf_s        = 1'b0;
        load_res_s   = 1'b1;
        load_flags_s = 1'b1;
        case (op_s)
            OP_ADD, OP_INC: begin
                value_s = sum_s[W-1:0];
                carry_s = sum_s[W];
                ovf_s   = add_ovf(operandA[W-1], addend_s[W-1], sum_s[W-1]);
            end
            OP_SUB, OP_DEC: begin
                value_s = diff_s[W-1:0];
                carry_s = diff_s[W];
                ovf_s   = sub_ovf(operandA[W-1], addend_s[W-1], diff_s[W-1]);
            end
            OP_CMP: begin
                value_s    = diff_s[W-1:0];
                carry_s    = diff_s[W];
                ovf_s      = sub_ovf(operandA[W-1], addend_s[W-1], diff_s[W-1]);
                load_res_s = 1'b0;
            end
            OP_AND: begin
                value_s = operandA & operandB;
            end
            OP_TST: begin
                value_s    = operandA & operandB;
                load_res_s = 1'b0;
            end
            OP_OR: begin
                value_s = operandA | operandB;
            end
            OP_XOR: begin
                value_s = operandA ^ operandB;
            end
            OP_NOT: begin
                value_s = ~operandA;
            end
            OP_MOV: begin
                value_s = operandB;
            end
            OP_LSL: begin
                value_s = lsl_s[W-1:0];
                carry_s = lsl_s[W];
            end
            OP_LSR: begin
                value_s = lsr_s[W:1];
                carry_s = lsr_s[0];
            end
            OP_ASR: begin
                value_s = asr_s[W:1];
                carry_s = asr_s[0];
            end
            OP_MUL: begin
                value_s = prod_s[W-1:0];
                carry_s = mul_ovf(prod_s);
                ovf_s   = mul_ovf(prod_s);
            end
            default: begin
                load_res_s   = 1'b0;
                load_flags_s = 1'b0;
            end
        endcase
    end

    // Next-state selection: load the new value or hold the previous one.
    always_comb begin
        res_d   = res_q;
        flags_d = flags_q;
        if (load_res_s) begin
            res_d = value_s;
        end else begin
            res_d = res_q;
        end
        if (load_flags_s) begin
            flags_d = pack_flags(value_s, carry_s, ovf_s);
        end else begin
            flags_d = flags_q;
        end
    end

    // Result and status registers. Reset clears both at once, without
    // waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= {W{1'b0}};
            flags_q <= 4'b0000;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign resultAccumulator = res_q;
    assign flags             = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector testbench for alu (W = 16) with hand-computed expectations.
module tb_alu;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [4:0]   alu_op;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [W-1:0] resultAccumulator;
    logic [3:0]   flags;

    int n_checks;
    int n_errors;

    alu #(.W(W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alu_op            (alu_op),
        .operandA          (operandA),
        .operandB          (operandB),
        .resultAccumulator (resultAccumulator),
        .flags             (flags)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one operation at the falling edge, sample just after the next
    // rising edge, and compare result and flags.
    task automatic run_vec(input string tag, input logic [4:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        alu_op   = op;
        operandA = a;
        operandB = b;
        @(posedge clk);
        #1;
        check_eq({tag, "_res"}, 32'(resultAccumulator), 32'(exp_res));
        check_eq({tag, "_flg"}, 32'(flags), 32'(exp_flags));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        alu_op   = 5'b00100;
        operandA = 16'h1234;
        operandB = 16'h5678;

        // Reset holds outputs at zero even with a MOV on the inputs.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_res", 32'(resultAccumulator), 32'h0);
        check_eq("rst_flg", 32'(flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // MOV
        run_vec("mov1", 5'b00100, 16'd32,   16'd5,   16'h0005, 4'b0000);
        run_vec("mov2", 5'b00100, 16'hFFF3, 16'hFFFD, 16'hFFFD, 4'b0100);
        run_vec("mov3", 5'b00100, 16'hFFF7, 16'h0001, 16'h0001, 4'b0000);

        // ADD / SUB
        run_vec("add_ovf", 5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        run_vec("add_cy",  5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        run_vec("sub_eq",  5'b00001, 16'd5,    16'd5,    16'h0000, 4'b1000);
        run_vec("sub_neg", 5'b00001, 16'd3,    16'd5,    16'hFFFE, 4'b0110);
        run_vec("sub_ovf", 5'b00001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);

        // CMP / TST hold the result
        run_vec("ld7",  5'b00100, 16'h0000, 16'd7,    16'h0007, 4'b0000);
        run_vec("cmp",  5'b01100, 16'd2,    16'd9,    16'h0007, 4'b0110);
        run_vec("tst",  5'b01101, 16'h00F0, 16'h0F00, 16'h0007, 4'b1000);

        // INC / DEC
        run_vec("inc", 5'b01010, 16'h7FFF, 16'h1234, 16'h8000, 4'b0101);
        run_vec("dec", 5'b01011, 16'h0000, 16'h1234, 16'hFFFF, 4'b0110);

        // Shifts
        run_vec("lsl1",   5'b00111, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
        run_vec("lsl0",   5'b00111, 16'h1234, 16'h0010, 16'h1234, 4'b0000);
        run_vec("asr15",  5'b01001, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100);
        run_vec("lsr3",   5'b01000, 16'h8000, 16'h0013, 16'h1000, 4'b0000);
        run_vec("lsr_c",  5'b01000, 16'h0005, 16'h0001, 16'h0002, 4'b0010);
        run_vec("asr_c",  5'b01001, 16'h8003, 16'h0002, 16'hE000, 4'b0110);

        // Logic
        run_vec("and", 5'b00010, 16'h0F0F, 16'hF0F0, 16'h0000, 4'b1000);
        run_vec("or",  5'b00011, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
        run_vec("xor", 5'b00101, 16'hFFFF, 16'h0F0F, 16'hF0F0, 4'b0100);
        run_vec("not", 5'b00110, 16'h0000, 16'hABCD, 16'hFFFF, 4'b0100);

        // MUL and NOP
        run_vec("mul_big", 5'b01110, 16'd300,  16'd300, 16'h5F90, 4'b0011);
        run_vec("mul_neg", 5'b01110, 16'hFFFC, 16'd5,   16'hFFEC, 4'b0100);
        run_vec("nop",     5'b11111, 16'h1111, 16'h2222, 16'hFFEC, 4'b0100);
        run_vec("nop2",    5'b10000, 16'h0000, 16'h0000, 16'hFFEC, 4'b0100);

        // Asynchronous reset between edges during an ADD sequence
        run_vec("add_pre", 5'b00000, 16'd1, 16'd2, 16'h0003, 4'b0000);
        @(negedge clk);
        alu_op   = 5'b00000;
        operandA = 16'h7FFF;
        operandB = 16'h0001;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_res", 32'(resultAccumulator), 32'h0);
        check_eq("arst_flg", 32'(flags), 32'h0);
        @(posedge clk);
        #1;
        check_eq("arst_hold_res", 32'(resultAccumulator), 32'h0);
        check_eq("arst_hold_flg", 32'(flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("add_post", 5'b00000, 16'd1, 16'd2, 16'h0003, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
